// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: op-index enum, opcode/func values and the
// illegal-op threshold. Also imported by the control unit.
package mips_pkg;

    typedef enum logic [4:0] {
        OP_SLL     = 5'd0,
        OP_SRL     = 5'd1,
        OP_SRA     = 5'd2,
        OP_JR      = 5'd3,
        OP_SYSCALL = 5'd4,
        OP_ADD     = 5'd5,
        OP_ADDU    = 5'd6,
        OP_SUB     = 5'd7,
        OP_SUBU    = 5'd8,
        OP_AND     = 5'd9,
        OP_OR      = 5'd10,
        OP_XOR     = 5'd11,
        OP_NOR     = 5'd12,
        OP_SLT     = 5'd13,
        OP_SLTU    = 5'd14,
        OP_J       = 5'd15,
        OP_JAL     = 5'd16,
        OP_BEQ     = 5'd17,
        OP_BNE     = 5'd18,
        OP_ADDI    = 5'd19,
        OP_ADDIU   = 5'd20,
        OP_SLTI    = 5'd21,
        OP_ANDI    = 5'd22,
        OP_ORI     = 5'd23,
        OP_LW      = 5'd24,
        OP_SW      = 5'd25
    } op_e;

    // Op indices at or above this value are illegal.
    localparam logic [4:0] OP_ILLEGAL_MIN = 5'd26;

    localparam logic [5:0] OPC_SPECIAL = 6'd0;
    localparam logic [5:0] OPC_J       = 6'd2;
    localparam logic [5:0] OPC_JAL     = 6'd3;
    localparam logic [5:0] OPC_BEQ     = 6'd4;
    localparam logic [5:0] OPC_BNE     = 6'd5;
    localparam logic [5:0] OPC_ADDI    = 6'd8;
    localparam logic [5:0] OPC_ADDIU   = 6'd9;
    localparam logic [5:0] OPC_SLTI    = 6'd10;
    localparam logic [5:0] OPC_ANDI    = 6'd12;
    localparam logic [5:0] OPC_ORI     = 6'd13;
    localparam logic [5:0] OPC_LW      = 6'd35;
    localparam logic [5:0] OPC_SW      = 6'd43;

    localparam logic [5:0] FN_SLL     = 6'd0;
    localparam logic [5:0] FN_SRL     = 6'd2;
    localparam logic [5:0] FN_SRA     = 6'd3;
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_SYSCALL = 6'd12;
    localparam logic [5:0] FN_ADD     = 6'd32;
    localparam logic [5:0] FN_ADDU    = 6'd33;
    localparam logic [5:0] FN_SUB     = 6'd34;
    localparam logic [5:0] FN_SUBU    = 6'd35;
    localparam logic [5:0] FN_AND     = 6'd36;
    localparam logic [5:0] FN_OR      = 6'd37;
    localparam logic [5:0] FN_XOR     = 6'd38;
    localparam logic [5:0] FN_NOR     = 6'd39;
    localparam logic [5:0] FN_SLT     = 6'd42;
    localparam logic [5:0] FN_SLTU    = 6'd43;

    // Output queue payload is {addr, word}.
    localparam int ENC_PAYLOAD_W = 64;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

endpackage

// File: rtl/enc_fifo.sv
// Two-entry output queue holding {addr, word}; head is presented unregistered.
// count_nxt exposes next-cycle occupancy so the parent can register in_ready.
module enc_fifo
    import mips_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENC_PAYLOAD_W-1:0] din,
    output logic                     valid,
    output logic [ENC_PAYLOAD_W-1:0] dout,
    output logic [1:0]               count_nxt
);

    logic [ENC_PAYLOAD_W-1:0] mem_q [2];
    logic [ENC_PAYLOAD_W-1:0] mem_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    assign valid     = (cnt_q != 2'd0);
    assign dout      = valid ? mem_q[rd_ptr_q] : '0;
    assign count_nxt = cnt_d;

    // State registers; reset drops any buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: op index + fields in, 32-bit word + address out.
// Optional macro INSTR_ENC_BRANCH_REL_EN: beq/bne take an absolute byte target
// in in_imm and encode the PC-relative word offset; otherwise in_imm[15:0] is
// used verbatim.
module instr_encoder
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err
);

    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        in_ready_q, in_ready_d;

    fmt_e        fmt;
    logic [5:0]  opcode, func;
    logic        use_rs, use_rt, use_rd, use_sh;
    logic [15:0] imm16;
    logic [31:0] word;
    logic        op_legal, accept, push, pop;
    logic [1:0]  count_nxt;
    logic [63:0] fifo_dout;
    logic        unused_imm;

`ifdef INSTR_ENC_BRANCH_REL_EN
    logic        is_branch;
    logic [31:0] br_off;
`endif

    // Decode op index into format, opcode/func and which fields survive.
    always_comb begin
        fmt    = FMT_R;
        opcode = OPC_SPECIAL;
        func   = FN_SLL;
        use_rs = 1'b1;
        use_rt = 1'b1;
        use_rd = 1'b1;
        use_sh = 1'b0;
        case (op_e'(in_op))
            OP_SLL:     begin func = FN_SLL; use_rs = 1'b0; use_sh = 1'b1; end
            OP_SRL:     begin func = FN_SRL; use_rs = 1'b0; use_sh = 1'b1; end
            OP_SRA:     begin func = FN_SRA; use_rs = 1'b0; use_sh = 1'b1; end
            OP_JR:      begin func = FN_JR; use_rt = 1'b0; use_rd = 1'b0; end
            OP_SYSCALL: begin func = FN_SYSCALL; use_rs = 1'b0; use_rt = 1'b0; use_rd = 1'b0; end
            OP_ADD:     func = FN_ADD;
            OP_ADDU:    func = FN_ADDU;
            OP_SUB:     func = FN_SUB;
            OP_SUBU:    func = FN_SUBU;
            OP_AND:     func = FN_AND;
            OP_OR:      func = FN_OR;
            OP_XOR:     func = FN_XOR;
            OP_NOR:     func = FN_NOR;
            OP_SLT:     func = FN_SLT;
            OP_SLTU:    func = FN_SLTU;
            OP_J:       begin fmt = FMT_J; opcode = OPC_J; end
            OP_JAL:     begin fmt = FMT_J; opcode = OPC_JAL; end
            OP_BEQ:     begin fmt = FMT_I; opcode = OPC_BEQ; end
            OP_BNE:     begin fmt = FMT_I; opcode = OPC_BNE; end
            OP_ADDI:    begin fmt = FMT_I; opcode = OPC_ADDI; end
            OP_ADDIU:   begin fmt = FMT_I; opcode = OPC_ADDIU; end
            OP_SLTI:    begin fmt = FMT_I; opcode = OPC_SLTI; end
            OP_ANDI:    begin fmt = FMT_I; opcode = OPC_ANDI; end
            OP_ORI:     begin fmt = FMT_I; opcode = OPC_ORI; end
            OP_LW:      begin fmt = FMT_I; opcode = OPC_LW; end
            OP_SW:      begin fmt = FMT_I; opcode = OPC_SW; end
            default:    fmt = FMT_R;
        endcase
    end

    // Immediate selection; branch offset is relative to the delay-slot PC.
`ifdef INSTR_ENC_BRANCH_REL_EN
    always_comb begin
        is_branch = (in_op == OP_BEQ) || (in_op == OP_BNE);
        br_off    = in_imm - (addr_q + 32'd4);
        imm16     = is_branch ? br_off[17:2] : in_imm[15:0];
    end
`else
    always_comb begin
        imm16 = in_imm[15:0];
    end
`endif

    // Assemble the word, zeroing fields the op does not use.
    always_comb begin
        case (fmt)
            FMT_I:   word = {opcode, in_rs, in_rt, imm16};
            FMT_J:   word = {opcode, in_imm[27:2]};
            default: word = {OPC_SPECIAL,
                             use_rs ? in_rs : 5'd0,
                             use_rt ? in_rt : 5'd0,
                             use_rd ? in_rd : 5'd0,
                             use_sh ? in_shamt : 5'd0,
                             func};
        endcase
    end

    assign unused_imm = ^in_imm[31:28];

    assign op_legal = (in_op < OP_ILLEGAL_MIN);
    assign accept   = in_valid && in_ready_q;
    assign push     = accept && op_legal;
    assign pop      = out_valid && out_ready;

    enc_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       ({addr_q, word}),
        .valid     (out_valid),
        .dout      (fifo_dout),
        .count_nxt (count_nxt)
    );

    assign out_addr = fifo_dout[63:32];
    assign out_word = fifo_dout[31:0];
    assign in_ready = in_ready_q;
    assign err      = err_q;

    // Next address, sticky error, and registered ready from next occupancy.
    always_comb begin
        addr_d     = push ? addr_q + 32'd4 : addr_q;
        err_d      = err_q | (accept & ~op_legal);
        in_ready_d = (count_nxt != 2'd2);
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; popped words are captured at negedge.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word, out_addr;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_w[$];
    logic [31:0] got_a[$];

    instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so a word seen here is consumed next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_w.push_back(out_word);
            got_a.push_back(out_addr);
        end
    end

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        in_op = 5'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        got_w.delete(); got_a.delete();
    endtask

    // Presents a request (at posedge+1) and returns just after the accepting edge.
    task automatic send(input logic [4:0] op, rs, rt, rd, sh, input logic [31:0] imm, output bit ok);
        ok = 1'b0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 40; i++) begin
            if (got_w.size() >= n) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b err=%b, expected 0 0 0", out_valid, in_ready, err);
        end
        n_checks++;
        if (out_word !== 32'h0 || out_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: word=%h addr=%h, expected 0 0", out_word, out_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: in_ready=%b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, ok);
        in_valid = 1'b0;
        // Accepted at the last edge: output must be visible right now.
        n_checks++;
        if (!ok || out_valid !== 1'b1 || out_word !== 32'h00221820 || out_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL add_latency: ok=%b valid=%b word=%h addr=%h, expected 1 1 00221820 00000000", ok, out_valid, out_word, out_addr);
        end
        wait_words(1);
        n_checks++;
        if (got_w.size() != 1 || got_w[0] !== 32'h00221820) begin
            n_fail++;
            $display("FAIL add_word: count=%0d, expected 1 word 00221820", got_w.size());
        end
    endtask

    task automatic test_addi_lw();
        bit ok1, ok2;
        do_reset();
        out_ready = 1'b1;
        send(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 32'd5, ok1);
        send(5'd24, 5'd29, 5'd9, 5'd0, 5'd0, 32'd4, ok2);
        in_valid = 1'b0;
        wait_words(2);
        n_checks++;
        if (!ok1 || !ok2 || got_w.size() != 2) begin
            n_fail++;
            $display("FAIL addi_lw_count: got %0d words, expected 2", got_w.size());
        end else begin
            n_checks++;
            if (got_w[0] !== 32'h20080005 || got_a[0] !== 32'h0) begin
                n_fail++;
                $display("FAIL addi_word: %h@%h, expected 20080005@00000000", got_w[0], got_a[0]);
            end
            n_checks++;
            if (got_w[1] !== 32'h8FA90004 || got_a[1] !== 32'h4) begin
                n_fail++;
                $display("FAIL lw_word: %h@%h, expected 8fa90004@00000004", got_w[1], got_a[1]);
            end
        end
    endtask

    task automatic test_fields();
        logic [31:0] exp_w [7];
        bit ok;
        bit all_ok = 1'b1;
        exp_w = '{32'h000220C0, 32'h03E00008, 32'h0000000C, 32'h08100004,
                  32'h20080005, 32'h00221825, 32'h0085302B};
        do_reset();
        out_ready = 1'b1;
        send(5'd0,  5'd7,  5'd2,  5'd4,  5'd3,  32'd0, ok);        all_ok &= ok; // sll, rs dropped
        send(5'd3,  5'd31, 5'd9,  5'd9,  5'd9,  32'hFFFF, ok);     all_ok &= ok; // jr
        send(5'd4,  5'd1,  5'd1,  5'd1,  5'd1,  32'hFFFF, ok);     all_ok &= ok; // syscall
        send(5'd15, 5'd3,  5'd3,  5'd3,  5'd3,  32'hF0400013, ok); all_ok &= ok; // j
        send(5'd19, 5'd0,  5'd8,  5'd5,  5'd7,  32'hFFFF0005, ok); all_ok &= ok; // addi
        send(5'd10, 5'd1,  5'd2,  5'd3,  5'd5,  32'd0, ok);        all_ok &= ok; // or, shamt dropped
        send(5'd14, 5'd4,  5'd5,  5'd6,  5'd0,  32'd0, ok);        all_ok &= ok; // sltu
        in_valid = 1'b0;
        wait_words(7);
        n_checks++;
        if (!all_ok || got_w.size() != 7) begin
            n_fail++;
            $display("FAIL fields_count: got %0d words, expected 7", got_w.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (got_w[i] !== exp_w[i] || got_a[i] !== 32'(i * 4)) begin
                    n_fail++;
                    $display("FAIL fields_word%0d: %h@%h, expected %h@%h", i, got_w[i], got_a[i], exp_w[i], 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        do_reset();
        out_ready = 1'b0;
        send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, ok1);
        send(5'd7, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0, ok2);
        in_op = 5'd6; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_shamt = 5'd0; in_imm = 32'd0;
        @(negedge clk);
        n_checks++;
        if (!ok1 || !ok2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full_ready: ok=%b%b in_ready=%b, expected 11 0", ok1, ok2, in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || got_w.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_stall: in_ready=%b popped=%0d, expected 0 0", in_ready, got_w.size());
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok3 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) ok3 = 1'b1;
            @(posedge clk); #1;
            if (ok3) break;
        end
        in_valid = 1'b0;
        wait_words(3);
        n_checks++;
        if (!ok3 || got_w.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words, expected 3", got_w.size());
        end else begin
            n_checks++;
            if (got_w[0] !== 32'h00221820 || got_w[1] !== 32'h00853022 || got_w[2] !== 32'h00E84821 ||
                got_a[0] !== 32'h0 || got_a[1] !== 32'h4 || got_a[2] !== 32'h8) begin
                n_fail++;
                $display("FAIL b2b_order: %h@%h %h@%h %h@%h, expected 00221820@0 00853022@4 00e84821@8",
                         got_w[0], got_a[0], got_w[1], got_a[1], got_w[2], got_a[2]);
            end
        end
    endtask

    task automatic test_stream();
        bit ok;
        bit all_ok = 1'b1;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(5'd20, 5'd0, 5'(i), 5'd0, 5'd0, 32'(i + 16), ok);
            all_ok &= ok;
        end
        in_valid = 1'b0;
        wait_words(5);
        n_checks++;
        if (!all_ok || got_w.size() != 5) begin
            n_fail++;
            $display("FAIL stream_count: got %0d words, expected 5", got_w.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_w[i] !== ((32'd9 << 26) | (32'(i) << 16) | 32'(i + 16)) || got_a[i] !== 32'(i * 4)) begin
                    n_fail++;
                    $display("FAIL stream_word%0d: %h@%h, expected %h@%h", i, got_w[i], got_a[i],
                             (32'd9 << 26) | (32'(i) << 16) | 32'(i + 16), 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_illegal();
        bit ok1, ok2, ok3;
        do_reset();
        out_ready = 1'b1;
        send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, ok1);
        send(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 32'd0, ok2);
        send(5'd8, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0, ok3);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok1 || !ok2 || !ok3 || got_w.size() != 2) begin
            n_fail++;
            $display("FAIL illegal_count: accepted=%b%b%b words=%0d, expected 111 2", ok1, ok2, ok3, got_w.size());
        end else begin
            n_checks++;
            if (got_w[0] !== 32'h00221820 || got_a[0] !== 32'h0 || got_w[1] !== 32'h00853023 || got_a[1] !== 32'h4) begin
                n_fail++;
                $display("FAIL illegal_words: %h@%h %h@%h, expected 00221820@0 00853023@4", got_w[0], got_a[0], got_w[1], got_a[1]);
            end
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err_sticky: err=%b, expected 1", err);
        end
    endtask

    task automatic test_branch();
        bit ok1, ok2;
        do_reset();
        out_ready = 1'b1;
`ifdef INSTR_ENC_BRANCH_REL_EN
        send(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_0010, ok1);
        send(5'd18, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_0000, ok2);
`else
        send(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_0003, ok1);
        send(5'd18, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_FFFE, ok2);
`endif
        in_valid = 1'b0;
        wait_words(2);
        n_checks++;
        if (!ok1 || !ok2 || got_w.size() != 2) begin
            n_fail++;
            $display("FAIL branch_count: got %0d words, expected 2", got_w.size());
        end else begin
            n_checks++;
            if (got_w[0] !== 32'h10220003 || got_w[1] !== 32'h1422FFFE) begin
                n_fail++;
                $display("FAIL branch_words: %h %h, expected 10220003 1422fffe", got_w[0], got_w[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, ok3;
        do_reset();
        out_ready = 1'b0;
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, ok3);
        send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, ok1);
        send(5'd7, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0, ok2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok1 || !ok2 || !ok3 || out_valid !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: ok=%b%b%b out_valid=%b in_ready=%b err=%b, expected 111 0 0 0",
                     ok1, ok2, ok3, out_valid, in_ready, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 32'd5, ok1);
        in_valid = 1'b0;
        wait_words(1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok1 || got_w.size() != 1 || got_w[0] !== 32'h20080005 || got_a[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: words=%0d, expected exactly 20080005@00000000", got_w.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_op = 5'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 32'd0;
        test_reset();
        test_add();
        test_addi_lw();
        test_fields();
        test_back_to_back();
        test_stream();
        test_illegal();
        test_branch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
